// File: rtl/console_rx.sv
// console_rx: 8N1 serial receiver with a receive FIFO behind a Wishbone slave.
// Register map (ADR[2]): 0 = DATA (read pops one byte), 1 = STATUS (write clears sticky flags).
module console_rx #(
    parameter int FREQUENCY    = 25000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = FREQUENCY / BAUD_RATE,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        CYC,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADR,
    input  logic [31:0] DAT_O,
    output logic [31:0] DAT_I,
    output logic        ACK,
    output logic        irq
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          sync1_q, sync2_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_done_s;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          ovr_q, ovr_d, ferr_q, ferr_d;
    logic          ack_q, ack_d, irq_q, irq_d;
    logic [31:0]   dat_q, dat_d;

    logic          full_s, empty_s, bus_req_s, pop_s, push_s, stat_wr_s;
    logic [7:0]    cnt8_s;
    logic          unused_s;

    assign unused_s = &{1'b0, ADR[31:3], ADR[1:0], DAT_O[31:4], DAT_O[1:0]};

    // Receive FSM next state: mid-bit sampling timed from the start-bit midpoint.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        frame_done_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sync2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d        = '0;
                    frame_done_s = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    assign full_s    = (count_q == NW'(FIFO_DEPTH));
    assign empty_s   = (count_q == '0);
    assign cnt8_s    = 8'(count_q);
    // One access per idle bus state; the access happens on the edge that raises the ack flag.
    assign bus_req_s = CYC & STB & ~ack_q;
    assign pop_s     = bus_req_s & ~WE & ~ADR[2] & ~empty_s;
    assign stat_wr_s = bus_req_s & WE & ADR[2];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign push_s    = frame_done_s & sync2_q & (~full_s | pop_s);

    // FIFO bookkeeping, sticky flags and bus response.
    always_comb begin
        wr_ptr_d = push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovr_d  = (frame_done_s & sync2_q & full_s & ~pop_s) | (ovr_q & ~(stat_wr_s & DAT_O[3]));
        ferr_d = (frame_done_s & ~sync2_q) | (ferr_q & ~(stat_wr_s & DAT_O[2]));
        ack_d  = bus_req_s;
        irq_d  = (count_d != '0);
        if (bus_req_s) begin
            if (WE) begin
                dat_d = 32'h0;
            end else if (ADR[2]) begin
                dat_d = {16'h0, cnt8_s, 4'h0, ovr_q, ferr_q, full_s, empty_s};
            end else if (!empty_s) begin
                dat_d = {23'h0, 1'b1, mem_q[rd_ptr_q]};
            end else begin
                dat_d = 32'h0;
            end
        end else begin
            dat_d = dat_q;
        end
    end

    // All control state, synchronizer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
            dat_q    <= 32'h0;
        end else begin
            sync1_q  <= rx;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            ack_q    <= ack_d;
            irq_q    <= irq_d;
            dat_q    <= dat_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= shift_q;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign ACK   = ack_q & CYC & STB;
    assign DAT_I = dat_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_console_rx.sv
// Self-checking bench for console_rx (CLKS_PER_BIT = 8, FIFO_DEPTH = 4).
module tb_console_rx;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int OP_SEND = 0, OP_GLITCH = 1, OP_RD = 2, OP_WR = 3, OP_IRQ = 4;

    logic        clk = 1'b0;
    logic        rst, rx, CYC, STB, WE, ACK, irq;
    logic [31:0] ADR, DAT_O, DAT_I;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          op;
        logic [7:0]  b;
        logic        stop;
        logic        adr;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t tbl[$];

    // Reference model state: queue of received bytes plus sticky flags.
    logic [7:0] mq[$];
    bit         m_ovr, m_ferr;

    console_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx), .CYC(CYC), .STB(STB), .WE(WE),
        .ADR(ADR), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK(ACK), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic send_settle(input logic [7:0] b, input logic stop);
        send_frame(b, stop);
        idle(12);
    endtask

    task automatic bus(input logic we, input logic adr2, input logic [31:0] wd, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = 32'h0;
        @(posedge clk);
        #1;
        CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr2 ? 32'h4 : 32'h0; DAT_O = wd;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk);
            #1;
            if (ACK) begin
                got = 1'b1;
                rd  = DAT_I;
            end
        end
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bus_ack actual=none required=ack_within_8");
        end
    endtask

    task automatic add(input int op, input logic [7:0] b, input logic stop, input logic adr,
                       input logic [31:0] wd, input logic [31:0] exp, input string name);
        vec_t v;
        v.op = op; v.b = b; v.stop = stop; v.adr = adr; v.wd = wd; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'h0;
        s[15:8] = 8'(mq.size());
        s[3] = m_ovr;
        s[2] = m_ferr;
        s[1] = (mq.size() == DEPTH);
        s[0] = (mq.size() == 0);
        return s;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        logic        stop;
        logic [31:0] wd;
        int          r;

        rst = 1'b1; rx = 1'b1; CYC = 1'b0; STB = 1'b0; WE = 1'b0; ADR = 32'h0; DAT_O = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {31'h0, ACK}, 32'h0);
        check("reset_dat", DAT_I, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        idle(4);

        // Directed table: inputs and hand-derived expectations.
        add(OP_RD,     8'h00, 1'b0, 1'b1, 32'h0, 32'h0000_0001, "status_after_reset");
        add(OP_SEND,   8'h55, 1'b1, 1'b0, 32'h0, 32'h0,         "send_55");
        add(OP_IRQ,    8'h00, 1'b0, 1'b0, 32'h0, 32'h1,         "irq_after_55");
        add(OP_RD,     8'h00, 1'b0, 1'b0, 32'h0, 32'h0000_0155, "data_55");
        add(OP_IRQ,    8'h00, 1'b0, 1'b0, 32'h0, 32'h0,         "irq_after_pop");
        add(OP_GLITCH, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,         "glitch");
        add(OP_RD,     8'h00, 1'b0, 1'b1, 32'h0, 32'h0000_0001, "status_glitch");
        add(OP_SEND,   8'hA3, 1'b0, 1'b0, 32'h0, 32'h0,         "send_a3_badstop");
        add(OP_RD,     8'h00, 1'b0, 1'b1, 32'h0, 32'h0000_0005, "status_ferr");
        add(OP_WR,     8'h00, 1'b0, 1'b1, 32'h4, 32'h0,         "clear_ferr");
        add(OP_RD,     8'h00, 1'b0, 1'b1, 32'h0, 32'h0000_0001, "status_ferr_clr");
        for (int i = 1; i <= 5; i++) add(OP_SEND, 8'(i), 1'b1, 1'b0, 32'h0, 32'h0, "send_seq");
        add(OP_RD,     8'h00, 1'b0, 1'b1, 32'h0, 32'h0000_040A, "status_full_ovr");
        for (int i = 1; i <= 4; i++) add(OP_RD, 8'h00, 1'b0, 1'b0, 32'h0, 32'h100 + 32'(i), "data_seq");
        add(OP_RD,     8'h00, 1'b0, 1'b0, 32'h0, 32'h0000_0000, "data_empty");
        add(OP_RD,     8'h00, 1'b0, 1'b1, 32'h0, 32'h0000_0009, "status_ovr_only");
        add(OP_WR,     8'h00, 1'b0, 1'b1, 32'h8, 32'h0,         "clear_ovr");
        add(OP_RD,     8'h00, 1'b0, 1'b1, 32'h0, 32'h0000_0001, "status_ovr_clr");
        add(OP_SEND,   8'h33, 1'b1, 1'b0, 32'h0, 32'h0,         "send_33");
        add(OP_WR,     8'h00, 1'b0, 1'b0, 32'hFF, 32'h0,        "data_write");
        add(OP_RD,     8'h00, 1'b0, 1'b0, 32'h0, 32'h0000_0133, "data_33");

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                OP_SEND: send_settle(tbl[i].b, tbl[i].stop);
                OP_GLITCH: begin
                    @(posedge clk);
                    #1;
                    rx = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                    rx = 1'b1;
                    idle(16);
                end
                OP_RD: begin
                    bus(1'b0, tbl[i].adr, 32'h0, rd);
                    check(tbl[i].name, rd, tbl[i].exp);
                end
                OP_WR: bus(1'b1, tbl[i].adr, tbl[i].wd, rd);
                OP_IRQ: check(tbl[i].name, {31'h0, irq}, tbl[i].exp);
                default: ;
            endcase
        end

        // Reset during bit 3 of a frame, with a bus cycle pending and a byte queued.
        send_settle(8'h11, 1'b1);
        check("irq_before_rst", {31'h0, irq}, 32'h1);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = 32'h0;
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        check("midrst_ack", {31'h0, ACK}, 32'h0);
        check("midrst_dat", DAT_I, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        idle(3);
        check("midrst_ack_held", {31'h0, ACK}, 32'h0);
        CYC = 1'b0; STB = 1'b0;
        rst = 1'b0;
        idle(20);
        bus(1'b0, 1'b1, 32'h0, rd);
        check("status_after_midrst", rd, 32'h0000_0001);
        send_settle(8'h7E, 1'b1);
        bus(1'b0, 1'b0, 32'h0, rd);
        check("data_7e", rd, 32'h0000_017E);

        // DATA read on the exact edge a byte lands in a full FIFO.
        for (int i = 0; i < 4; i++) send_settle(8'hA0 + 8'(i), 1'b1);
        bus(1'b0, 1'b1, 32'h0, rd);
        check("status_prefull", rd, 32'h0000_0402);
        fork
            send_frame(8'hC5, 1'b1);
            begin
                @(posedge clk);
                repeat (78) @(posedge clk);
                #1;
                CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = 32'h0;
                @(posedge clk);
                #1;
                check("race_ack", {31'h0, ACK}, 32'h1);
                check("race_data", DAT_I, 32'h0000_01A0);
                CYC = 1'b0; STB = 1'b0;
            end
        join
        idle(12);
        bus(1'b0, 1'b1, 32'h0, rd);
        check("status_after_race", rd, 32'h0000_0402);
        for (int i = 1; i < 4; i++) begin
            bus(1'b0, 1'b0, 32'h0, rd);
            check("race_drain", rd, 32'h100 + 32'h0A0 + 32'(i));
        end
        bus(1'b0, 1'b0, 32'h0, rd);
        check("race_drain_c5", rd, 32'h0000_01C5);

        // Randomized traffic against the queue model.
        mq.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                b    = 8'($urandom);
                stop = ($urandom_range(0, 7) != 0);
                send_settle(b, stop);
                if (!stop) m_ferr = 1'b1;
                else if (mq.size() < DEPTH) mq.push_back(b);
                else m_ovr = 1'b1;
            end else if (r < 7) begin
                bus(1'b0, 1'b0, 32'h0, rd);
                if (mq.size() > 0) check("rand_data", rd, {23'h0, 1'b1, mq.pop_front()});
                else check("rand_data_empty", rd, 32'h0);
            end else if (r == 7) begin
                bus(1'b0, 1'b1, 32'h0, rd);
                check("rand_status", rd, model_status());
            end else if (r == 8) begin
                wd = $urandom;
                bus(1'b1, 1'b1, wd, rd);
                if (wd[3]) m_ovr = 1'b0;
                if (wd[2]) m_ferr = 1'b0;
            end else begin
                bus(1'b1, 1'b0, $urandom, rd);
            end
        end
        bus(1'b0, 1'b1, 32'h0, rd);
        check("rand_final_status", rd, model_status());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
